// File: rtl/rr_bus_arbiter.sv
// Round-robin owner selection for a shared 4-source bus. It drives the select code
// and one-hot tri-state enables, bounds each tenure, and adds a dead cycle between owners.
module rr_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [CW-1:0] hold_cnt,
  output logic [1:0]    state_dbg,
  output logic [1:0]    ptr_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] hold_q, hold_d;

  logic [1:0]    win_idx;
  logic [1:0]    cand;
  logic          others_req;

  // Scan from the farthest offset down so the first requester at or after ptr wins.
  always_comb begin
    win_idx = ptr_q;
    cand    = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) win_idx = cand;
    end
  end

  assign others_req = |(req & ~(4'b0001 << sel_q));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, TURN: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          hold_d  = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      GRANT: begin
        if (!req[sel_q] || (hold_q == MAX_C && others_req)) begin
          state_d = TURN;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          hold_d  = '0;
        end else if (hold_q != MAX_C) begin
          hold_d  = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign hold_cnt  = hold_q;
  assign state_dbg = state_q;
  assign ptr_dbg   = ptr_q;

endmodule
